// File: rtl/pt_dump_pkg.sv
// Shared definitions for the key-crack datapath: FSM state codes and stream constants.
package pt_dump_pkg;

  localparam int KEY_BYTES = 3;
  localparam int LEN_ADDR  = 0;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_RD_LEN  = 4'd1;
  localparam state_t ST_WT_LEN  = 4'd2;
  localparam state_t ST_KEY     = 4'd3;
  localparam state_t ST_RD_BYTE = 4'd4;
  localparam state_t ST_WT_BYTE = 4'd5;
  localparam state_t ST_SEND    = 4'd6;
  localparam state_t ST_FIN     = 4'd7;

  // Key bytes go out most-significant first.
  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = k[23:16];
      2'd1:    b = k[15:8];
      default: b = k[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pt_dump_if.sv
// Start handshake, plaintext RAM port and output byte stream of pt_dump.
interface pt_dump_if #(
  parameter int ADDR_W = 8
);
  logic              en;
  logic              rdy;
  logic [23:0]       key;
  logic              done;
  logic [ADDR_W-1:0] pt_addr;
  logic [7:0]        pt_rddata;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output en, key, pt_rddata, out_ready,
    input  rdy, done, pt_addr, out_data, out_valid
  );

  modport slave (
    input  en, key, pt_rddata, out_ready,
    output rdy, done, pt_addr, out_data, out_valid
  );
endinterface

// File: rtl/pt_dump.sv
// Streams the cracked key (optional) followed by the length-prefixed plaintext
// held in an external synchronous RAM, one byte per valid/ready handshake.
module pt_dump
  import pt_dump_pkg::*;
#(
  parameter int SEND_KEY = 1,
  parameter int ADDR_W   = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  pt_dump_if.slave bus
);

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [ADDR_W-1:0] pt_addr_q, pt_addr_d;
  logic [8:0]        index_q, index_d;
  logic [7:0]        len_q, len_d;
  logic [23:0]       key_q, key_d;
  logic [1:0]        kcnt_q, kcnt_d;

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pt_addr_d   = pt_addr_q;
    index_d     = index_q;
    len_d       = len_q;
    key_d       = key_q;
    kcnt_d      = kcnt_q;

    case (state_q)
      ST_IDLE: begin
        rdy_d       = 1'b1;
        out_valid_d = 1'b0;
        if (rdy_q && bus.en) begin
          rdy_d     = 1'b0;
          key_d     = bus.key;
          index_d   = 9'd0;
          pt_addr_d = ADDR_W'(LEN_ADDR);
          state_d   = ST_RD_LEN;
        end
      end

      ST_RD_LEN: state_d = ST_WT_LEN;

      ST_WT_LEN: begin
        len_d = bus.pt_rddata;
        if (SEND_KEY != 0) begin
          kcnt_d      = 2'd0;
          out_data_d  = key_byte(key_q, 2'd0);
          out_valid_d = 1'b1;
          state_d     = ST_KEY;
        end else if (bus.pt_rddata == 8'd0) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          index_d   = 9'd1;
          pt_addr_d = ADDR_W'(9'd1);
          state_d   = ST_RD_BYTE;
        end
      end

      ST_KEY: begin
        if (bus.out_ready) begin
          if (kcnt_q == 2'(KEY_BYTES - 1)) begin
            out_valid_d = 1'b0;
            if (len_q == 8'd0) begin
              done_d  = 1'b1;
              state_d = ST_FIN;
            end else begin
              index_d   = 9'd1;
              pt_addr_d = ADDR_W'(9'd1);
              state_d   = ST_RD_BYTE;
            end
          end else begin
            kcnt_d     = kcnt_q + 2'd1;
            out_data_d = key_byte(key_q, kcnt_q + 2'd1);
          end
        end
      end

      // The address is already registered on entry so the RAM samples it this cycle.
      ST_RD_BYTE: begin
        pt_addr_d = ADDR_W'(index_q);
        state_d   = ST_WT_BYTE;
      end

      ST_WT_BYTE: begin
        out_data_d  = bus.pt_rddata;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (index_q == {1'b0, len_q}) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            index_d   = index_q + 9'd1;
            pt_addr_d = ADDR_W'(index_q + 9'd1);
            state_d   = ST_RD_BYTE;
          end
        end
      end

      ST_FIN: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        rdy_d       = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = 8'd0;
        pt_addr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      pt_addr_q   <= '0;
      index_q     <= 9'd0;
      len_q       <= 8'd0;
      key_q       <= 24'd0;
      kcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pt_addr_q   <= pt_addr_d;
      index_q     <= index_d;
      len_q       <= len_d;
      key_q       <= key_d;
      kcnt_q      <= kcnt_d;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pt_addr   = pt_addr_q;

endmodule

// File: tb/tb_pt_dump.sv
// Directed bench for pt_dump: one instance with key streaming, one without.
module tb_pt_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_drv;
  logic        ready_drv;
  logic        rnd_ready;
  logic        sel;
  logic [23:0] key_drv;
  logic [7:0]  mem [256];
  logic [7:0]  rd_a, rd_b;

  pt_dump_if #(.ADDR_W(8)) ifa ();
  pt_dump_if #(.ADDR_W(8)) ifb ();

  pt_dump #(.SEND_KEY(1), .ADDR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pt_dump #(.SEND_KEY(0), .ADDR_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always @(posedge clk) begin
    rd_a <= mem[ifa.pt_addr];
    rd_b <= mem[ifb.pt_addr];
  end

  assign ifa.pt_rddata = rd_a;
  assign ifb.pt_rddata = rd_b;
  assign ifa.en        = en_drv & ~sel;
  assign ifb.en        = en_drv & sel;
  assign ifa.key       = key_drv;
  assign ifb.key       = key_drv;
  assign ifa.out_ready = ready_drv;
  assign ifb.out_ready = ready_drv;

  wire       rdy_m   = sel ? ifb.rdy       : ifa.rdy;
  wire       en_m    = sel ? ifb.en        : ifa.en;
  wire       done_m  = sel ? ifb.done      : ifa.done;
  wire       valid_m = sel ? ifb.out_valid : ifa.out_valid;
  wire [7:0] data_m  = sel ? ifb.out_data  : ifa.out_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor of the selected instance, sampled on the falling edge.
  int cyc = 0, done_cnt = 0, acc_cnt = 0, last_acc = 0, last_done = 0;
  int valid_cnt = 0, stab_viol = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'd0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (valid_m) valid_cnt++;
      if (prev_v && !prev_r && (!valid_m || data_m != prev_d)) stab_viol++;
      if (valid_m && ready_drv) got_q.push_back(data_m);
      if (done_m) begin
        done_cnt++;
        last_done = cyc;
      end
      if (rdy_m && en_m) begin
        acc_cnt++;
        last_acc = cyc;
      end
      prev_v = valid_m;
      prev_r = ready_drv;
      prev_d = data_m;
    end
  end

  initial begin
    ready_drv = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_drv = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_dump(input logic s, input logic [23:0] k);
    int n = 0;
    sel     = s;
    key_drv = k;
    while (!rdy_m && n < 100) begin
      tick();
      n++;
    end
    en_drv = 1'b1;
    tick();
    en_drv = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      tick();
      n++;
    end
    if (done_cnt == base) chk("done_timeout", done_cnt - base, 1);
  endtask

  task automatic add_exp(input logic with_key, input logic [23:0] k);
    if (with_key) begin
      exp_q.push_back(k[23:16]);
      exp_q.push_back(k[15:8]);
      exp_q.push_back(k[7:0]);
    end
    for (int i = 1; i <= int'(mem[0]); i++) exp_q.push_back(mem[i]);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  int base, vbase, sbase, abase, d1, n;

  initial begin
    rst_n = 1'b0; en_drv = 1'b0; sel = 1'b0; key_drv = 24'd0; rnd_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_rdy", ifa.rdy, 0);
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_addr", ifa.pt_addr, 0);
    chk("rst_data", ifa.out_data, 0);
    rst_n = 1'b1;
    chk("rdy_before_edge", ifa.rdy, 0);
    tick();
    chk("rdy_after_edge", ifa.rdy, 1);

    // Key + "abc", ready always high
    mem[0] = 8'd3; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
    got_q.delete(); exp_q.delete(); base = done_cnt;
    start_dump(1'b0, 24'h00033C);
    wait_done(base, 200);
    repeat (3) tick();
    add_exp(1'b1, 24'h00033C);
    chk_stream("s1");
    chk("s1_done_cnt", done_cnt - base, 1);
    chk("s1_latency", last_done - last_acc, 15);

    // L=0 without key: nothing streamed
    mem[0] = 8'd0;
    got_q.delete(); base = done_cnt; vbase = valid_cnt;
    start_dump(1'b1, 24'hABCDEF);
    wait_done(base, 200);
    repeat (3) tick();
    chk("s2_valid", valid_cnt - vbase, 0);
    chk("s2_bytes", got_q.size(), 0);
    chk("s2_latency", last_done - last_acc, 3);
    chk("s2_done_cnt", done_cnt - base, 1);

    // L=2 without key
    mem[0] = 8'd2; mem[1] = 8'h11; mem[2] = 8'h22;
    got_q.delete(); exp_q.delete(); base = done_cnt;
    start_dump(1'b1, 24'h123456);
    wait_done(base, 200);
    add_exp(1'b0, 24'h0);
    chk_stream("s2b");
    chk("s2b_latency", last_done - last_acc, 9);

    // L=255, mem[i]=i
    mem[0] = 8'd255;
    for (int i = 1; i < 256; i++) mem[i] = 8'(i);
    got_q.delete(); exp_q.delete(); base = done_cnt;
    start_dump(1'b0, 24'h123456);
    wait_done(base, 2000);
    add_exp(1'b1, 24'h123456);
    chk_stream("s3");
    chk("s3_latency", last_done - last_acc, 771);

    // Random back-pressure
    mem[0] = 8'd5;
    for (int i = 1; i <= 5; i++) mem[i] = 8'(8'hA0 + i - 1);
    got_q.delete(); exp_q.delete(); base = done_cnt; sbase = stab_viol;
    rnd_ready = 1'b1;
    start_dump(1'b0, 24'hC0FFEE);
    wait_done(base, 500);
    rnd_ready = 1'b0;
    tick(); tick();
    add_exp(1'b1, 24'hC0FFEE);
    chk_stream("s4");
    chk("s4_stable", stab_viol - sbase, 0);
    chk("s4_done_cnt", done_cnt - base, 1);

    // Reset while the 2nd plaintext byte is presented
    mem[0] = 8'd3; mem[1] = 8'h78; mem[2] = 8'h79; mem[3] = 8'h7A;
    got_q.delete(); base = done_cnt;
    start_dump(1'b0, 24'h010203);
    n = 0;
    while (!(got_q.size() == 4 && valid_m) && n < 200) begin
      tick();
      n++;
    end
    chk("s5_reach", got_q.size(), 4);
    rst_n = 1'b0;
    #1;
    chk("s5_valid_drop", ifa.out_valid, 0);
    chk("s5_rdy_low", ifa.rdy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("s5_rdy_after", ifa.rdy, 1);
    repeat (3) tick();
    chk("s5_no_done", done_cnt - base, 0);
    chk("s5_bytes", got_q.size(), 4);
    got_q.delete(); exp_q.delete(); base = done_cnt;
    start_dump(1'b0, 24'h010203);
    wait_done(base, 200);
    add_exp(1'b1, 24'h010203);
    chk_stream("s5_fresh");

    // en held high across done
    mem[0] = 8'd2; mem[1] = 8'h70; mem[2] = 8'h71;
    got_q.delete(); exp_q.delete(); base = done_cnt; abase = acc_cnt;
    sel = 1'b0; key_drv = 24'hAA55AA;
    n = 0;
    while (!rdy_m && n < 100) begin
      tick();
      n++;
    end
    en_drv = 1'b1;
    wait_done(base, 200);
    d1 = last_done;
    chk("s6_busy_acc", acc_cnt - abase, 1);
    n = 0;
    while (acc_cnt - abase < 2 && n < 20) begin
      tick();
      n++;
    end
    en_drv = 1'b0;
    chk("s6_restart", last_acc - d1, 1);
    wait_done(base + 1, 200);
    add_exp(1'b1, 24'hAA55AA);
    add_exp(1'b1, 24'hAA55AA);
    chk_stream("s6");
    chk("s6_done_cnt", done_cnt - base, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
